// File: rtl/rgb_fade_seq.sv
// ----------------------------------------------------------------------------
// rgb_fade_seq
//
// Colour-fade sequencer for an RGB LED driver. A prescaler turns the clock
// into step ticks. On each tick a three-state FSM ramps an internal
// brightness level up to full scale, holds it there for HOLD_TICKS ticks,
// and then ramps it back down to zero. When a fade completes, the sequencer
// moves on to the next colour in the cycle red -> green -> blue -> white.
// The internal level is routed to the output(s) of the active colour.
//
// Parameters
//   WIDTH       bit width of each brightness level output
//   PRESCALER   one step tick every PRESCALER+1 enabled clocks
//   HOLD_TICKS  ticks spent at full brightness (>= 1)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       1 = sequencer runs, 0 = everything frozen
//   restart      synchronous return to red, level 0 (beats tick and enable)
//   level_red    registered duty level for the red PWM stage
//   level_green  registered duty level for the green PWM stage
//   level_blue   registered duty level for the blue PWM stage
//   color_idx    active colour: 0=red 1=green 2=blue 3=white
//   color_done   one-clock pulse, coincident with the color_idx advance
// ----------------------------------------------------------------------------
module rgb_fade_seq #(
    parameter int WIDTH      = 8,
    parameter int PRESCALER  = 0,
    parameter int HOLD_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    output logic [WIDTH-1:0] level_red,
    output logic [WIDTH-1:0] level_green,
    output logic [WIDTH-1:0] level_blue,
    output logic [1:0]       color_idx,
    output logic             color_done
);

    // Counters need at least one bit even when their range collapses to 0.
    localparam int PRE_W  = (PRESCALER  > 0) ? $clog2(PRESCALER + 1) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS)    : 1;

    localparam logic [WIDTH-1:0]  LEVEL_MAX = '1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALER);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD      = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    state_t             state,    nxt_state;
    logic [WIDTH-1:0]   level,    nxt_level;
    logic [HOLD_W-1:0]  hold_cnt, nxt_hold_cnt;
    logic [1:0]         nxt_idx;
    logic               nxt_done;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [WIDTH-1:0]   nxt_red, nxt_green, nxt_blue;

    assign tick = enable && (pre_cnt == PRE_LAST);

    // Next-state logic. Without a tick everything keeps its value, which is
    // also what freezes the sequencer while enable is low.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        nxt_state    = state;
        nxt_level    = level;
        nxt_hold_cnt = hold_cnt;
        nxt_idx      = color_idx;
        nxt_done     = 1'b0;

        if (tick) begin
            case (state)
                RAMP_UP: begin
                    // Reaching full scale costs one tick of its own before
                    // the hold count starts, so the level never overflows.
                    if (level == LEVEL_MAX) begin
                        nxt_state    = HOLD;
                        nxt_hold_cnt = '0;
                    end else begin
                        nxt_level = level + WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        nxt_state = RAMP_DOWN;
                    end else begin
                        nxt_hold_cnt = hold_cnt + HOLD_W'(1);
                    end
                end
                RAMP_DOWN: begin
                    if (level == '0) begin
                        nxt_state = RAMP_UP;
                        nxt_idx   = color_idx + 2'd1;  // 3 wraps to 0
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_level = level - WIDTH'(1);
                    end
                end
                default: begin
                    nxt_state = RAMP_UP;
                    nxt_level = '0;
                end
            endcase
        end
    end

    // Output routing is computed from the next values so the registered
    // outputs move in the same clock as the internal level and colour.
    always_comb begin
        nxt_red   = (nxt_idx == 2'd0 || nxt_idx == 2'd3) ? nxt_level : '0;
        nxt_green = (nxt_idx == 2'd1 || nxt_idx == 2'd3) ? nxt_level : '0;
        nxt_blue  = (nxt_idx == 2'd2 || nxt_idx == 2'd3) ? nxt_level : '0;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only control and output registers exist here; there is no
            // memory array, so a full asynchronous reset is cheap and safe.
            state       <= RAMP_UP;
            level       <= '0;
            hold_cnt    <= '0;
            pre_cnt     <= '0;
            color_idx   <= 2'd0;
            color_done  <= 1'b0;
            level_red   <= '0;
            level_green <= '0;
            level_blue  <= '0;
        end else if (restart) begin
            state       <= RAMP_UP;
            level       <= '0;
            hold_cnt    <= '0;
            pre_cnt     <= '0;
            color_idx   <= 2'd0;
            color_done  <= 1'b0;
            level_red   <= '0;
            level_green <= '0;
            level_blue  <= '0;
        end else begin
            if (enable) begin
                pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            end
            state       <= nxt_state;
            level       <= nxt_level;
            hold_cnt    <= nxt_hold_cnt;
            color_idx   <= nxt_idx;
            color_done  <= nxt_done;
            level_red   <= nxt_red;
            level_green <= nxt_green;
            level_blue  <= nxt_blue;
        end
    end

endmodule

// File: tb/tb_rgb_fade_seq.sv
// ----------------------------------------------------------------------------
// tb_rgb_fade_seq
//
// Self-checking bench for rgb_fade_seq. Two instances share the stimulus:
// one with PRESCALER=0 and one with PRESCALER=3 (both WIDTH=4, HOLD_TICKS=2).
// The reference model only counts enabled clocks since the last reset or
// restart; the expected outputs are derived from that count by arithmetic
// on the colour period (ticks = clocks / (PRESCALER+1), 34 ticks per colour).
// ----------------------------------------------------------------------------
module tb_rgb_fade_seq;

    localparam int W      = 4;
    localparam int HOLD   = 2;
    localparam int M      = (1 << W) - 1;
    localparam int PERIOD = 2 * (1 << W) + HOLD;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         restart = 1'b0;
    logic [W-1:0] r0, g0, b0, r3, g3, b3;
    logic [1:0]   idx0, idx3;
    logic         done0, done3;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: enabled clocks since reset/restart, and the done flag
    // expected for the most recent edge.
    int e0 = 0, e3 = 0;
    bit d0 = 0, d3 = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    rgb_fade_seq #(.WIDTH(W), .PRESCALER(0), .HOLD_TICKS(HOLD)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .level_red(r0), .level_green(g0), .level_blue(b0),
        .color_idx(idx0), .color_done(done0)
    );

    rgb_fade_seq #(.WIDTH(W), .PRESCALER(3), .HOLD_TICKS(HOLD)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .level_red(r3), .level_green(g3), .level_blue(b3),
        .color_idx(idx3), .color_done(done3)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected packed {red, green, blue, idx, done} from the clock count.
    function automatic int model_out(input int e, input int p, input bit done);
        int t, k, idx, lvl, r, g, b;
        t   = e / (p + 1);
        k   = t % PERIOD;
        idx = (t / PERIOD) % 4;
        if (k <= M)              lvl = k;
        else if (k <= M + 1 + HOLD) lvl = M;
        else                     lvl = M - (k - (M + 1 + HOLD));
        r = (idx == 0 || idx == 3) ? lvl : 0;
        g = (idx == 1 || idx == 3) ? lvl : 0;
        b = (idx == 2 || idx == 3) ? lvl : 0;
        return (r << 11) | (g << 7) | (b << 3) | (idx << 1) | int'(done);
    endfunction

    function automatic int pack0();
        return int'({r0, g0, b0, idx0, done0});
    endfunction

    function automatic int pack3();
        return int'({r3, g3, b3, idx3, done3});
    endfunction

    // Advance one model by one clock edge with the given inputs.
    task automatic model_step(inout int e, inout bit d, input int p,
                              input bit en, input bit rs);
        int t;
        if (rs) begin
            e = 0;
            d = 0;
        end else if (en) begin
            e++;
            t = e / (p + 1);
            d = (e % (p + 1) == 0) && (t % PERIOD == 0) && (t > 0);
        end else begin
            d = 0;
        end
    endtask

    // Called at a falling edge: apply inputs, predict, compare next falling edge.
    task automatic cycle(input bit en, input bit rs);
        enable  = en;
        restart = rs;
        model_step(e0, d0, 0, en, rs);
        model_step(e3, d3, 3, en, rs);
        @(negedge clk);
        check("dut_p0", pack0(), model_out(e0, 0, d0));
        check("dut_p3", pack3(), model_out(e3, 3, d3));
        if (done0) pulses++;
    endtask

    // Drop rst_n between edges and confirm outputs clear before the next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_p0", pack0(), 0);
        check("async_rst_p3", pack3(), 0);
        @(negedge clk);
        check("in_rst_p0", pack0(), 0);
        rst_n = 1'b1;
        e0 = 0; e3 = 0; d0 = 0; d3 = 0;
    endtask

    initial begin
        bit en, rs;
        @(negedge clk);
        @(negedge clk);
        check("reset_p0", pack0(), 0);
        check("reset_p3", pack3(), 0);
        rst_n = 1'b1;

        // One full four-colour cycle at a steady enable.
        pulses = 0;
        for (int i = 0; i < 4 * PERIOD; i++) cycle(1'b1, 1'b0);
        check("cycle_pulses", pulses, 4);
        check("cycle_idx", int'(idx0), 0);

        // Freeze in green ramp-up at level 7, then resume.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < PERIOD + 7; i++) cycle(1'b1, 1'b0);
        check("freeze_at_g7", int'(g0), 7);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        check("frozen_g7", int'(g0), 7);
        cycle(1'b1, 1'b0);
        check("resume_g8", int'(g0), 8);

        // Restart coincident with a tick at blue level 9.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 2 * PERIOD + 9; i++) cycle(1'b1, 1'b0);
        check("blue_9", int'(b0), 9);
        cycle(1'b1, 1'b1);
        check("restart_clear", pack0(), 0);

        // Randomized run with occasional freezes, restarts and async resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                en = ($urandom_range(0, 4) != 0);
                rs = ($urandom_range(0, 399) == 0);
                cycle(en, rs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
